// File: rtl/id_ex_pipe_pkg.sv
// Shared definitions for the ID/EX pipeline register: opcodes, forward selects,
// FSM states and the control word that EX receives for a bubble.
package id_ex_pipe_pkg;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_XOR    = 4'h2;
  localparam logic [3:0] OP_RED    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LHB    = 4'hA;
  localparam logic [3:0] OP_LLB    = 4'hB;
  localparam logic [3:0] OP_B      = 4'hC;
  localparam logic [3:0] OP_BR     = 4'hD;
  localparam logic [3:0] OP_PCS    = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_e;

  typedef struct packed {
    logic ldByte;
    logic memOp;
    logic memRead;
    logic memWrite;
    logic regWrite;
    logic valid;
  } ctrl_t;

  localparam ctrl_t BUBBLE_CTRL = '0;

  function automatic logic usesSrcA(input logic [3:0] op);
    return op <= OP_LLB;
  endfunction

  function automatic logic usesSrcB(input logic [3:0] op);
    return (op <= OP_RED) || (op == OP_PADDSB);
  endfunction

  // The younger producer sitting in MEM wins over the older one in WB.
  function automatic logic [1:0] selectFwd(input logic memHit, input logic wbHit);
    return {memHit, wbHit & ~memHit};
  endfunction

endpackage

// File: rtl/id_ex_pipe_hazard_unit.sv
// Source-field extraction and hazard/forward decision for the instruction in Decode.
// With ID_EX_FWD_EN defined only load-use stalls; otherwise every RAW hit stalls.
module id_ex_pipe_hazard_unit
  import id_ex_pipe_pkg::*;
#(
  parameter int REG_AW = 4
) (
  input  logic [15:0]       instr_i,
  input  logic              exValid_i,
  input  logic              exRegWrite_i,
`ifdef ID_EX_FWD_EN
  input  logic              exMemRead_i,
`endif
  input  logic [REG_AW-1:0] exDst_i,
  input  logic              memRegWrite_i,
  input  logic [REG_AW-1:0] memDst_i,
  output logic [1:0]        fwdA_o,
  output logic [1:0]        fwdB_o,
  output logic              hazard_o
);

  logic [3:0]        op;
  logic [REG_AW-1:0] srcA;
  logic [REG_AW-1:0] srcB;
  logic              useA, useB;
  logic              exHitA, exHitB, memHitA, memHitB;

  always_comb begin
    op      = instr_i[15:12];
    srcA    = (op == OP_LHB || op == OP_LLB) ? instr_i[8 +: REG_AW] : instr_i[4 +: REG_AW];
    srcB    = instr_i[0 +: REG_AW];
    // R0 is hardwired to zero, so it can never depend on an older writer.
    useA    = usesSrcA(op) && (srcA != '0);
    useB    = usesSrcB(op) && (srcB != '0);
    exHitA  = exValid_i && exRegWrite_i && (exDst_i == srcA);
    exHitB  = exValid_i && exRegWrite_i && (exDst_i == srcB);
    memHitA = memRegWrite_i && (memDst_i == srcA);
    memHitB = memRegWrite_i && (memDst_i == srcB);
`ifdef ID_EX_FWD_EN
    fwdA_o   = selectFwd(useA && exHitA && !exMemRead_i, useA && memHitA);
    fwdB_o   = selectFwd(useB && exHitB && !exMemRead_i, useB && memHitB);
    hazard_o = exValid_i && exMemRead_i &&
               ((useA && (exDst_i == srcA)) || (useB && (exDst_i == srcB)));
`else
    fwdA_o   = FWD_RF;
    fwdB_o   = FWD_RF;
    hazard_o = (useA && (exHitA || memHitA)) || (useB && (exHitB || memHitB));
`endif
  end

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register: latches Decode, registers forward selects, inserts bubbles
// on hazard/flush/HLT and freezes on hold. Forwarding is enabled by ID_EX_FWD_EN.
module id_ex_pipe
  import id_ex_pipe_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       instr_ID,
  input  logic [DATA_W-1:0] RegData1_ID,
  input  logic [DATA_W-1:0] RegData2_ID,
  input  logic [DATA_W-1:0] pcs_ID,
  input  logic              LdByte_ID,
  input  logic              MemOp_ID,
  input  logic              MemRead_ID,
  input  logic              MemWrite_ID,
  input  logic              RegWrite_ID,
  input  logic              valid_ID,
  input  logic              RegWrite_MEM,
  input  logic [REG_AW-1:0] dst_MEM,
  input  logic              hold,
  input  logic              flush,
  output logic [15:0]       instr_EX,
  output logic [DATA_W-1:0] RegData1_EX,
  output logic [DATA_W-1:0] RegData2_EX,
  output logic [DATA_W-1:0] pcs_EX,
  output logic              LdByte_EX,
  output logic              MemOp_EX,
  output logic              MemRead_EX,
  output logic              MemWrite_EX,
  output logic              RegWrite_EX,
  output logic              valid_EX,
  output logic [REG_AW-1:0] dst_EX,
  output logic [1:0]        ForwardA,
  output logic [1:0]        ForwardB,
  output logic              stall_ID,
  output logic              halted
);

  logic [15:0]       instr_q, instr_d;
  logic [DATA_W-1:0] rd1_q, rd1_d, rd2_q, rd2_d, pcs_q, pcs_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic [1:0]        fwdA_q, fwdA_d, fwdB_q, fwdB_d;
  state_e            state_q;
  logic [1:0]        fwdA, fwdB;
  logic              hazard, isHalted, bubble;

  id_ex_pipe_hazard_unit #(.REG_AW(REG_AW)) hazardUnit (
    .instr_i       (instr_ID),
    .exValid_i     (ctrl_q.valid),
    .exRegWrite_i  (ctrl_q.regWrite),
`ifdef ID_EX_FWD_EN
    .exMemRead_i   (ctrl_q.memRead),
`endif
    .exDst_i       (dst_EX),
    .memRegWrite_i (RegWrite_MEM),
    .memDst_i      (dst_MEM),
    .fwdA_o        (fwdA),
    .fwdB_o        (fwdB),
    .hazard_o      (hazard)
  );

  // Flush squashes the hazard's bubble cause, so Decode is free to advance.
  always_comb begin
    isHalted     = (state_q == HALTED);
    bubble       = isHalted || flush || hazard || !valid_ID;
    stall_ID     = hold || isHalted || (!flush && hazard);
    instr_d      = instr_ID;
    rd1_d        = RegData1_ID;
    rd2_d        = RegData2_ID;
    pcs_d        = pcs_ID;
    ctrl_d.ldByte   = LdByte_ID;
    ctrl_d.memOp    = MemOp_ID;
    ctrl_d.memRead  = MemRead_ID;
    ctrl_d.memWrite = MemWrite_ID;
    ctrl_d.regWrite = RegWrite_ID;
    ctrl_d.valid    = valid_ID;
    fwdA_d       = fwdA;
    fwdB_d       = fwdB;
    if (bubble) begin
      instr_d = '0;
      rd1_d   = '0;
      rd2_d   = '0;
      pcs_d   = '0;
      ctrl_d  = BUBBLE_CTRL;
      fwdA_d  = FWD_RF;
      fwdB_d  = FWD_RF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      pcs_q   <= '0;
      ctrl_q  <= BUBBLE_CTRL;
      fwdA_q  <= FWD_RF;
      fwdB_q  <= FWD_RF;
      state_q <= RUN;
    end else if (!hold) begin
      instr_q <= instr_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      pcs_q   <= pcs_d;
      ctrl_q  <= ctrl_d;
      fwdA_q  <= fwdA_d;
      fwdB_q  <= fwdB_d;
      if (!bubble && instr_ID[15:12] == OP_HLT) state_q <= HALTED;
    end
  end

  assign instr_EX    = instr_q;
  assign RegData1_EX = rd1_q;
  assign RegData2_EX = rd2_q;
  assign pcs_EX      = pcs_q;
  assign LdByte_EX   = ctrl_q.ldByte;
  assign MemOp_EX    = ctrl_q.memOp;
  assign MemRead_EX  = ctrl_q.memRead;
  assign MemWrite_EX = ctrl_q.memWrite;
  assign RegWrite_EX = ctrl_q.regWrite;
  assign valid_EX    = ctrl_q.valid;
  assign dst_EX      = instr_q[8 +: REG_AW];
  assign ForwardA    = fwdA_q;
  assign ForwardB    = fwdB_q;
  assign halted      = (state_q == HALTED);

endmodule

// File: tb/tb_id_ex_pipe.sv
// Self-checking bench for id_ex_pipe: directed pipeline scenarios then randomized traffic
// compared against an instruction-level reference model of the EX stage.
module tb_id_ex_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr_ID, RegData1_ID, RegData2_ID, pcs_ID;
  logic        LdByte_ID, MemOp_ID, MemRead_ID, MemWrite_ID, RegWrite_ID, valid_ID;
  logic        RegWrite_MEM;
  logic [3:0]  dst_MEM;
  logic        hold, flush;
  logic [15:0] instr_EX, RegData1_EX, RegData2_EX, pcs_EX;
  logic        LdByte_EX, MemOp_EX, MemRead_EX, MemWrite_EX, RegWrite_EX, valid_EX;
  logic [3:0]  dst_EX;
  logic [1:0]  ForwardA, ForwardB;
  logic        stall_ID, halted;

  int checks = 0;
  int errors = 0;

`ifdef ID_EX_FWD_EN
  localparam int         ADD_STALLS = 0;
  localparam logic [1:0] ADD_FWDA   = 2'b10;
  localparam int         LW_STALLS  = 1;
  localparam logic [1:0] LW_FWDA    = 2'b01;
`else
  localparam int         ADD_STALLS = 2;
  localparam logic [1:0] ADD_FWDA   = 2'b00;
  localparam int         LW_STALLS  = 2;
  localparam logic [1:0] LW_FWDA    = 2'b00;
`endif

  localparam logic [4:0] C_ALU = 5'b00001;
  localparam logic [4:0] C_LW  = 5'b01101;
  localparam logic [4:0] C_NONE = 5'b00000;

  // Reference EX stage and a shadow MEM stage used by the directed scenarios
  logic [15:0] mInstr, mRd1, mRd2, mPcs;
  logic        mLdb, mMop, mMrd, mMwr, mRw, mVld, mHalted;
  logic [1:0]  mFa, mFb;
  logic        autoMem, memRw;
  logic [3:0]  memDst;
  logic        expStall, expHaz, lastStall;
  logic [1:0]  expFa, expFb;
  int          nStall;

  always #5 clk = ~clk;

  id_ex_pipe dut (
    .clk(clk), .rst(rst), .instr_ID(instr_ID), .RegData1_ID(RegData1_ID),
    .RegData2_ID(RegData2_ID), .pcs_ID(pcs_ID), .LdByte_ID(LdByte_ID), .MemOp_ID(MemOp_ID),
    .MemRead_ID(MemRead_ID), .MemWrite_ID(MemWrite_ID), .RegWrite_ID(RegWrite_ID),
    .valid_ID(valid_ID), .RegWrite_MEM(RegWrite_MEM), .dst_MEM(dst_MEM), .hold(hold),
    .flush(flush), .instr_EX(instr_EX), .RegData1_EX(RegData1_EX), .RegData2_EX(RegData2_EX),
    .pcs_EX(pcs_EX), .LdByte_EX(LdByte_EX), .MemOp_EX(MemOp_EX), .MemRead_EX(MemRead_EX),
    .MemWrite_EX(MemWrite_EX), .RegWrite_EX(RegWrite_EX), .valid_EX(valid_EX),
    .dst_EX(dst_EX), .ForwardA(ForwardA), .ForwardB(ForwardB), .stall_ID(stall_ID),
    .halted(halted)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] fwdSel(input logic memHit, input logic wbHit);
    if (memHit) return 2'b10;
    if (wbHit)  return 2'b01;
    return 2'b00;
  endfunction

  task automatic modelReset();
    {mInstr, mRd1, mRd2, mPcs} = '0;
    {mLdb, mMop, mMrd, mMwr, mRw, mVld, mHalted} = '0;
    mFa = 2'b00; mFb = 2'b00;
    memRw = 1'b0; memDst = 4'h0;
  endtask

  // Dependence of the Decode instruction on the older instructions in EX and MEM
  task automatic modelPredict();
    logic [3:0] op, sA, sB, exDst;
    logic       uA, uB;
    op    = instr_ID[15:12];
    sA    = (op == 4'hA || op == 4'hB) ? instr_ID[11:8] : instr_ID[7:4];
    sB    = instr_ID[3:0];
    uA    = (op <= 4'hB) && (sA != 4'h0);
    uB    = (op <= 4'h3 || op == 4'h7) && (sB != 4'h0);
    exDst = mInstr[11:8];
`ifdef ID_EX_FWD_EN
    expFa  = fwdSel(uA && mVld && mRw && !mMrd && exDst == sA, uA && RegWrite_MEM && dst_MEM == sA);
    expFb  = fwdSel(uB && mVld && mRw && !mMrd && exDst == sB, uB && RegWrite_MEM && dst_MEM == sB);
    expHaz = mVld && mMrd && ((uA && exDst == sA) || (uB && exDst == sB));
`else
    expFa  = 2'b00;
    expFb  = 2'b00;
    expHaz = (uA && ((mVld && mRw && exDst == sA) || (RegWrite_MEM && dst_MEM == sA))) ||
             (uB && ((mVld && mRw && exDst == sB) || (RegWrite_MEM && dst_MEM == sB)));
`endif
    expStall = hold || mHalted || (!flush && expHaz);
  endtask

  task automatic modelEdge();
    if (hold) return;
    if (mHalted || flush || expHaz || !valid_ID) begin
      {mInstr, mRd1, mRd2, mPcs} = '0;
      {mLdb, mMop, mMrd, mMwr, mRw, mVld} = '0;
      mFa = 2'b00; mFb = 2'b00;
    end else begin
      mInstr = instr_ID; mRd1 = RegData1_ID; mRd2 = RegData2_ID; mPcs = pcs_ID;
      {mLdb, mMop, mMrd, mMwr, mRw} = {LdByte_ID, MemOp_ID, MemRead_ID, MemWrite_ID, RegWrite_ID};
      mVld = 1'b1; mFa = expFa; mFb = expFb;
      if (instr_ID[15:12] == 4'hF) mHalted = 1'b1;
    end
  endtask

  task automatic checkAll();
    checkOutput("data_EX", {instr_EX, RegData1_EX, RegData2_EX, pcs_EX}, {mInstr, mRd1, mRd2, mPcs});
    checkOutput("ctrl_EX", {LdByte_EX, MemOp_EX, MemRead_EX, MemWrite_EX, RegWrite_EX, valid_EX},
                {mLdb, mMop, mMrd, mMwr, mRw, mVld});
    checkOutput("dst_EX", dst_EX, mInstr[11:8]);
    checkOutput("fwd_EX", {ForwardA, ForwardB}, {mFa, mFb});
    checkOutput("halted", halted, mHalted);
  endtask

  // One clock: check the combinational stall, take the edge, check the EX register
  task automatic step();
    if (autoMem) begin RegWrite_MEM = memRw; dst_MEM = memDst; end
    #1;
    modelPredict();
    lastStall = stall_ID;
    checkOutput("stall_ID", stall_ID, expStall);
    @(posedge clk);
    if (!hold) begin memRw = mVld && mRw; memDst = mInstr[11:8]; end
    modelEdge();
    #1;
    checkAll();
  endtask

  task automatic doReset();
    rst = 1'b1;
    #3;
    modelReset();
    checkAll();
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input logic [15:0] ins, input logic [4:0] c);
    instr_ID = ins;
    {LdByte_ID, MemOp_ID, MemRead_ID, MemWrite_ID, RegWrite_ID} = c;
    valid_ID = 1'b1;
    RegData1_ID = 16'($urandom);
    RegData2_ID = 16'($urandom);
    pcs_ID = 16'($urandom);
  endtask

  // Hold the instruction in Decode until it is accepted (bounded)
  task automatic issue(input logic [15:0] ins, input logic [4:0] c, output int stalls);
    applyStimulus(ins, c);
    stalls = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (!lastStall) break;
      stalls++;
    end
  endtask

  task automatic drain();
    applyStimulus(16'h0000, C_NONE);
    valid_ID = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; flush = 1'b0; autoMem = 1'b1;
    RegWrite_MEM = 1'b0; dst_MEM = 4'h0; lastStall = 1'b0;
    applyStimulus(16'h0000, C_NONE);
    valid_ID = 1'b0;
    modelReset();
    @(posedge clk); #1;
    doReset();
    checkOutput("rst_stall", stall_ID, 1'b0);
    checkOutput("rst_valid", valid_EX, 1'b0);

    // Back-to-back ALU dependence
    issue(16'h0123, C_ALU, nStall);
    issue(16'h0415, C_ALU, nStall);
    checkOutput("add_stalls", nStall, ADD_STALLS);
    checkOutput("add_fwdA", ForwardA, ADD_FWDA);

    // Load-use
    drain();
    issue(16'h8120, C_LW, nStall);
    issue(16'h1213, C_ALU, nStall);
    checkOutput("lw_stalls", nStall, LW_STALLS);
    checkOutput("lw_fwdA", ForwardA, LW_FWDA);

    // R0 never creates a dependence
    drain();
    issue(16'h0023, C_ALU, nStall);
    issue(16'h2400, C_ALU, nStall);
    checkOutput("r0_stalls", nStall, 0);
    checkOutput("r0_fwd", {ForwardA, ForwardB}, 4'b0000);

    // Flush beats load-use
    drain();
    issue(16'h8120, C_LW, nStall);
    applyStimulus(16'h1213, C_ALU);
    flush = 1'b1;
    step();
    flush = 1'b0;
    checkOutput("flush_stall", lastStall, 1'b0);
    checkOutput("flush_valid", valid_EX, 1'b0);

    // Hold beats load-use, then reset during hold
    drain();
    issue(16'h8120, C_LW, nStall);
    applyStimulus(16'h1213, C_ALU);
    hold = 1'b1;
    step();
    checkOutput("hold_stall", lastStall, 1'b1);
    checkOutput("hold_instr", instr_EX, 16'h8120);
    checkOutput("hold_valid", valid_EX, 1'b1);
    doReset();
    checkOutput("hold_rst_valid", valid_EX, 1'b0);
    hold = 1'b0;
    drain();

    // HLT then ADD
    issue(16'hF000, C_NONE, nStall);
    checkOutput("hlt_halted", halted, 1'b1);
    applyStimulus(16'h0123, C_ALU);
    step();
    step();
    checkOutput("hlt_stall", lastStall, 1'b1);
    checkOutput("hlt_valid", valid_EX, 1'b0);
    doReset();
    checkOutput("hlt_rst", halted, 1'b0);

    // Randomized traffic with independent MEM-stage inputs
    autoMem = 1'b0;
    for (int i = 0; i < 600; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      applyStimulus({op, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))},
                    5'($urandom));
      valid_ID = ($urandom_range(0, 7) != 0);
      RegWrite_MEM = 1'($urandom);
      dst_MEM = 4'($urandom_range(0, 3));
      hold = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 7) == 0);
      if (mHalted && $urandom_range(0, 3) == 0) doReset();
      else step();
    end
    hold = 1'b0;
    flush = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
